// File: rtl/fetch_byte_queue.sv
// Byte-granular instruction queue: accepts 8-byte fetch chunks and presents a byte-aligned decode window.
// Optional protocol checker (proto_err port plus simulation $error) is enabled by defining FBQ_PROTOCOL_CHECK_EN.
module fetch_byte_queue #(
  parameter int DEPTH_BYTES  = 32,
  parameter int FILL_BYTES   = 8,
  parameter int WINDOW_BYTES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fill_valid,
  output logic                           fill_ready,
  input  logic [63:0]                    fill_data,
  input  logic                           flush,
  input  logic [63:0]                    flush_pc,
  output logic [WINDOW_BYTES*8-1:0]      window_bytes,
  output logic [$clog2(DEPTH_BYTES):0]   window_count,
  output logic [63:0]                    window_pc,
  input  logic                           consume_valid,
  input  logic [3:0]                     consume_len
`ifdef FBQ_PROTOCOL_CHECK_EN
  ,
  output logic                           proto_err
`endif
);

  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH_BYTES];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    skip;

  logic          fill_fire;
  logic          consume_legal;
  logic          consume_ok;
  logic [3:0]    fill_amt;

  assign fill_amt      = 4'(FILL_BYTES) - {1'b0, skip};
  assign fill_ready    = (count <= CW'(DEPTH_BYTES - FILL_BYTES));
  assign fill_fire     = fill_valid & fill_ready & ~flush;
  assign consume_legal = (consume_len != 4'd0) && (CW'(consume_len) <= count);
  assign consume_ok    = consume_valid & ~flush & consume_legal;
  assign window_count  = count;

  // Flush outranks fill and consume; a flushed cycle only reloads the PC and the skip offset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      skip      <= '0;
      window_pc <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      skip      <= flush_pc[2:0];
      window_pc <= flush_pc;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge state, even when fill and consume coincide.
      if (fill_fire) begin
        wr_ptr <= wr_ptr + PW'(fill_amt);
        skip   <= '0;
      end
      if (consume_ok) begin
        rd_ptr    <= rd_ptr + PW'(consume_len);
        window_pc <= window_pc + 64'(consume_len);
      end
      count <= count + (fill_fire ? CW'(fill_amt) : CW'(0))
                     - (consume_ok ? CW'(consume_len) : CW'(0));
    end
  end

  // NOTE: the byte array has no reset; the window masks everything at or beyond count, so stale bytes never escape.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      for (int k = 0; k < FILL_BYTES; k++) begin
        if (3'(k) >= skip) begin
          mem[wr_ptr + PW'(k) - PW'(skip)] <= fill_data[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    window_bytes = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (i < int'(count)) begin
        window_bytes[8*i +: 8] = mem[rd_ptr + PW'(i)];
      end
    end
  end

`ifdef FBQ_PROTOCOL_CHECK_EN
  logic consume_bad;
  assign consume_bad = consume_valid & ~flush & ~consume_legal;

  // A flush clears the sticky flag, but a fill offered alongside that flush is itself a violation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if (flush) begin
      proto_err <= fill_valid;
    end else if (consume_bad) begin
      proto_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      if (consume_bad)
        $error("fetch_byte_queue: illegal consume len=%0d count=%0d", consume_len, count);
      if (flush && fill_valid)
        $error("fetch_byte_queue: fill_valid asserted during flush");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed self-checking bench for fetch_byte_queue using a byte-queue reference model.
// Covers reset, fills, flush skip, full/backpressure, simultaneous fill+consume, pointer wrap and illegal consume.
module tb_fetch_byte_queue;

  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_valid;
  logic         fill_ready;
  logic [63:0]  fill_data;
  logic         flush;
  logic [63:0]  flush_pc;
  logic [127:0] window_bytes;
  logic [5:0]   window_count;
  logic [63:0]  window_pc;
  logic         consume_valid;
  logic [3:0]   consume_len;
`ifdef FBQ_PROTOCOL_CHECK_EN
  logic         proto_err;
`endif

  int checks   = 0;
  int failures = 0;

  byte unsigned mq[$];
  logic [63:0]  mpc;
  logic [2:0]   mskip;

  fetch_byte_queue dut (
    .clk           (clk),
    .reset         (reset),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_data     (fill_data),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .window_bytes  (window_bytes),
    .window_count  (window_count),
    .window_pc     (window_pc),
    .consume_valid (consume_valid),
    .consume_len   (consume_len)
`ifdef FBQ_PROTOCOL_CHECK_EN
    ,
    .proto_err     (proto_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] chunk(input logic [7:0] base);
    logic [63:0] c;
    for (int k = 0; k < 8; k++) c[8*k +: 8] = base + 8'(k);
    return c;
  endfunction

  // Reference model: a byte queue updated from the offered inputs before the edge.
  task automatic model_step(input logic fv, input logic [63:0] fd, input logic cv,
                            input logic [3:0] cl, input logic fl, input logic [63:0] fpc);
    bit rdy;
    bit legal;
    if (fl) begin
      mq.delete();
      mpc   = fpc;
      mskip = fpc[2:0];
    end else begin
      rdy   = (DEPTH - mq.size()) >= 8;
      legal = cv && (cl != 0) && (int'(cl) <= mq.size());
      if (legal) begin
        for (int i = 0; i < int'(cl); i++) void'(mq.pop_front());
        mpc = mpc + 64'(cl);
      end
      if (fv && rdy) begin
        for (int k = int'(mskip); k < 8; k++) mq.push_back(fd[8*k +: 8]);
        mskip = '0;
      end
    end
  endtask

  task automatic cycle(input logic fv, input logic [63:0] fd, input logic cv,
                       input logic [3:0] cl, input logic fl, input logic [63:0] fpc);
    fill_valid    = fv;
    fill_data     = fd;
    consume_valid = cv;
    consume_len   = cl;
    flush         = fl;
    flush_pc      = fpc;
    model_step(fv, fd, cv, cl, fl, fpc);
    @(posedge clk);
    #1;
    fill_valid    = 1'b0;
    consume_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [127:0] exp;
    exp = '0;
    for (int i = 0; i < 16; i++) if (i < mq.size()) exp[8*i +: 8] = mq[i];
    check({tag, ".count"}, 128'(window_count), 128'(mq.size()));
    check({tag, ".pc"},    128'(window_pc),    128'(mpc));
    check({tag, ".win"},   window_bytes,       exp);
    check({tag, ".ready"}, 128'(fill_ready),   128'((DEPTH - mq.size()) >= 8));
  endtask

  initial begin
    int          n;
    logic [7:0]  base;
    bit          acc;

    reset = 1'b0; fill_valid = 1'b0; fill_data = '0; flush = 1'b0; flush_pc = '0;
    consume_valid = 1'b0; consume_len = '0;
    mpc = '0; mskip = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.ready", 128'(fill_ready),   128'(1));
    check("reset.count", 128'(window_count), 128'(0));
    check("reset.win",   window_bytes,       128'(0));
    check("reset.pc",    128'(window_pc),    128'(0));
`ifdef FBQ_PROTOCOL_CHECK_EN
    check("reset.proto", 128'(proto_err),    128'(0));
`endif
    reset = 1'b1;

    // Two aligned fills
    cycle(1, 64'h0706050403020100, 0, 0, 0, 0);
    cycle(1, 64'h0F0E0D0C0B0A0908, 0, 0, 0, 0);
    check("fill2.count", 128'(window_count),  128'(16));
    check("fill2.b0",    128'(window_bytes[7:0]),     128'h00);
    check("fill2.b15",   128'(window_bytes[127:120]), 128'h0F);
    check("fill2.pc",    128'(window_pc),     128'(0));
    check("fill2.win",   window_bytes, 128'h0F0E0D0C0B0A09080706050403020100);

    // Flush discards an offered consume, then a chunk with 3 leading bytes skipped
    cycle(0, 0, 1, 4, 1, 64'h1003);
    check("flush.count", 128'(window_count), 128'(0));
    check("flush.pc",    128'(window_pc),    128'h1003);
    check("flush.win",   window_bytes,       128'(0));
    cycle(1, 64'h1716151413121110, 0, 0, 0, 0);
    check("skip.count",  128'(window_count), 128'(5));
    check("skip.b0",     128'(window_bytes[7:0]), 128'h13);
    check("skip.pc",     128'(window_pc),    128'h1003);
    check("skip.win",    window_bytes,       128'h1716151413);

    // Fill to full, hold a chunk under backpressure, consume 8 to release it
    cycle(0, 0, 0, 0, 1, 64'h2000);
    for (int c = 0; c < 4; c++) cycle(1, chunk(8'hA0 + 8'(8*c)), 0, 0, 0, 0);
    check("full.count",  128'(window_count), 128'(32));
    check("full.ready",  128'(fill_ready),   128'(0));
    cycle(1, chunk(8'hC0), 0, 0, 0, 0);
    check("hold.count",  128'(window_count), 128'(32));
    check("hold.ready",  128'(fill_ready),   128'(0));
    cycle(1, chunk(8'hC0), 1, 8, 0, 0);
    check("drain.count", 128'(window_count), 128'(24));
    check("drain.ready", 128'(fill_ready),   128'(1));
    cycle(1, chunk(8'hC0), 0, 0, 0, 0);
    check("refill.count", 128'(window_count), 128'(32));
    check("refill.pc",    128'(window_pc),    128'h2008);
    check_model("refill");

    // Simultaneous fill and consume from count=10
    cycle(0, 0, 0, 0, 1, 64'h3006);
    cycle(1, chunk(8'h30), 0, 0, 0, 0);
    cycle(1, chunk(8'h38), 0, 0, 0, 0);
    check("ten.count", 128'(window_count), 128'(10));
    cycle(1, chunk(8'h40), 1, 3, 0, 0);
    check("fc.count", 128'(window_count), 128'(15));
    check("fc.pc",    128'(window_pc),    128'h3009);
    check("fc.b0",    128'(window_bytes[7:0]),     128'h39);
    check("fc.b14",   128'(window_bytes[119:112]), 128'h47);
    check("fc.b15",   128'(window_bytes[127:120]), 128'h00);

    // Pointer wrap: stream byte i has value i
    cycle(0, 0, 0, 0, 1, 64'h0);
    cycle(1, chunk(8'h00), 0, 0, 0, 0);
    n = 1;
    for (int it = 0; it < 20; it++) begin
      base = 8'(8 * n);
      acc  = (DEPTH - mq.size()) >= 8;
      cycle(1, chunk(base), 1, 5, 0, 0);
      if (acc) n++;
      check_model($sformatf("wrap%0d", it));
    end
    check("wrap.pc", 128'(window_pc),         128'(100));
    check("wrap.b0", 128'(window_bytes[7:0]), 128'(100));

    // Illegal consumes leave state untouched
    cycle(0, 0, 0, 0, 1, 64'h4000);
    cycle(1, chunk(8'h50), 0, 0, 0, 0);
    cycle(0, 0, 1, 6, 0, 0);
    check("pre.count", 128'(window_count), 128'(2));
    cycle(0, 0, 1, 4, 0, 0);
    check("ill.count", 128'(window_count), 128'(2));
    check("ill.pc",    128'(window_pc),    128'h4006);
    check("ill.win",   window_bytes,       128'h5756);
`ifdef FBQ_PROTOCOL_CHECK_EN
    check("ill.proto", 128'(proto_err),    128'(1));
`endif
    cycle(0, 0, 1, 0, 0, 0);
    check("zero.count", 128'(window_count), 128'(2));
    check("zero.pc",    128'(window_pc),    128'h4006);
    cycle(0, 0, 0, 0, 1, 64'h5000);
`ifdef FBQ_PROTOCOL_CHECK_EN
    check("flush.proto", 128'(proto_err), 128'(0));
`endif

    // Reset mid-operation
    cycle(1, chunk(8'h60), 0, 0, 0, 0);
    check("mid.count", 128'(window_count), 128'(8));
    reset = 1'b0;
    #2;
    check("rst2.count", 128'(window_count), 128'(0));
    check("rst2.pc",    128'(window_pc),    128'(0));
    check("rst2.win",   window_bytes,       128'(0));
    check("rst2.ready", 128'(fill_ready),   128'(1));
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
